// File: rtl/vga_fb_scanout_pkg.sv
// vga_fb_scanout_pkg: VGA 640x480@60 timing constants and 320x240x3 framebuffer geometry
package vga_fb_scanout_pkg;
  localparam int H_VIS = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_VIS = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC - 1;
  localparam int FB_W = 320;
  localparam int FB_H = 240;
  localparam int FB_WORDS = FB_W * FB_H;
  localparam int COL_W = 3;
  localparam int ADDR_W = 17;
  localparam int CNT_W = 10;
  typedef logic [COL_W-1:0] colour_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;
  // row*320 + col without a multiplier
  function automatic fb_addr_t fb_addr(input logic [8:0] row, input logic [8:0] col);
    return ({8'd0, row} << 8) + ({8'd0, row} << 6) + {8'd0, col};
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 25 MHz pixel tick from 50 MHz clk, h/v scan counters and region decode
module vga_timing_gen import vga_fb_scanout_pkg::*; #(
  parameter int H_VIS = vga_fb_scanout_pkg::H_VIS,
  parameter int H_FP = vga_fb_scanout_pkg::H_FP,
  parameter int H_SYNC = vga_fb_scanout_pkg::H_SYNC,
  parameter int H_BP = vga_fb_scanout_pkg::H_BP,
  parameter int V_VIS = vga_fb_scanout_pkg::V_VIS,
  parameter int V_FP = vga_fb_scanout_pkg::V_FP,
  parameter int V_SYNC = vga_fb_scanout_pkg::V_SYNC,
  parameter int V_BP = vga_fb_scanout_pkg::V_BP
) (
  input  logic             clk,
  input  logic             reset,
  output logic             phase,
  output logic             tick,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             vis,
  output logic             hs_n,
  output logic             vs_n,
  output logic             frame_start
);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST = CNT_W'(V_VIS + V_FP + V_SYNC - 1);
  always_ff @(posedge clk)
    if (reset) begin
      phase <= 1'b0;
      h <= '0;
      v <= '0;
    end else begin
      phase <= !phase;
      if (phase) begin
        h <= (h == H_LAST) ? '0 : CNT_W'(h + 1);
        if (h == H_LAST) v <= (v == V_LAST) ? '0 : CNT_W'(v + 1);
      end
    end
  assign tick = phase;
  assign vis = (h < H_VIS_C) && (v < V_VIS_C);
  assign hs_n = !((h >= HS_FIRST) && (h <= HS_LAST));
  assign vs_n = !((v >= VS_FIRST) && (v <= VS_LAST));
  assign frame_start = phase && (h == '0) && (v == '0);
endmodule

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: 320x240x3 plot-written framebuffer scanned out as 2x2-replicated 640x480 VGA
module vga_fb_scanout import vga_fb_scanout_pkg::*; #(
  parameter int H_VIS = vga_fb_scanout_pkg::H_VIS,
  parameter int H_FP = vga_fb_scanout_pkg::H_FP,
  parameter int H_SYNC = vga_fb_scanout_pkg::H_SYNC,
  parameter int H_BP = vga_fb_scanout_pkg::H_BP,
  parameter int V_VIS = vga_fb_scanout_pkg::V_VIS,
  parameter int V_FP = vga_fb_scanout_pkg::V_FP,
  parameter int V_SYNC = vga_fb_scanout_pkg::V_SYNC,
  parameter int V_BP = vga_fb_scanout_pkg::V_BP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       plot,
  input  logic [8:0] x,
  input  logic [7:0] y,
  input  logic [2:0] colour,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] VGA_R,
  output logic [9:0] VGA_G,
  output logic [9:0] VGA_B,
  output logic       frame_start
);
  logic phase, tick, vis, hs_n, vs_n, wr_en, vis_q, hs_q, vs_q;
  logic [CNT_W-1:0] h, v;
  colour_t fb [FB_WORDS];
  colour_t rdata;
  fb_addr_t raddr_q;
  vga_timing_gen #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .reset(reset), .phase(phase), .tick(tick), .h(h), .v(v),
    .vis(vis), .hs_n(hs_n), .vs_n(vs_n), .frame_start(frame_start)
  );
  assign wr_en = plot && !reset && (x < 9'(FB_W)) && (y < 8'(FB_H));
  // read every clk: raddr_q is stable between ticks, and a same-edge write yields old data
  always_ff @(posedge clk) begin
    if (wr_en) fb[fb_addr({1'b0, y}, x)] <= colour;
    rdata <= fb[raddr_q];
  end
  always_ff @(posedge clk)
    if (reset) begin
      raddr_q <= '0;
      vis_q <= 1'b0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
      VGA_BLANK_N <= 1'b0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else if (tick) begin
      raddr_q <= vis ? fb_addr(9'(v >> 1), 9'(h >> 1)) : '0;
      vis_q <= vis;
      hs_q <= hs_n;
      vs_q <= vs_n;
      VGA_R <= vis_q ? {10{rdata[2]}} : '0;
      VGA_G <= vis_q ? {10{rdata[1]}} : '0;
      VGA_B <= vis_q ? {10{rdata[0]}} : '0;
      VGA_BLANK_N <= vis_q;
      VGA_HS <= hs_q;
      VGA_VS <= vs_q;
    end
  assign VGA_CLK = phase;
  assign VGA_SYNC_N = 1'b1;
endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: reduced-timing scanout checked every clk against a clk-count pixel model
module tb_vga_fb_scanout;
  localparam int HV = 64, HF = 4, HSY = 8, HB = 4, HT = HV + HF + HSY + HB;
  localparam int VV = 48, VF = 2, VSY = 2, VB = 4, VT = VV + VF + VSY + VB;
  localparam int FR = HT * VT;
  localparam logic [35:0] RST = {6'b011010, 30'd0};
  localparam logic [29:0] MAG = {10'h3FF, 10'h000, 10'h3FF};
  localparam logic [29:0] GRN = {10'h000, 10'h3FF, 10'h000};
  localparam logic [29:0] WHT = {30{1'b1}};
  localparam logic [29:0] BLK = 30'd0;
  typedef struct {
    logic we;
    logic [8:0] wx;
    logic [7:0] wy;
    logic [2:0] wc;
    int ph;
    int pv;
    logic [29:0] rgb;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, plot = 1'b0;
  logic [8:0] x = '0;
  logic [7:0] y = '0;
  logic [2:0] colour = '0;
  logic vga_clk, hs, vs, blank_n, sync_n, frame_start;
  logic [9:0] r, g, b;
  logic [35:0] got;
  int vectors = 0, miscompares = 0, t = 0, base = 0, c = 0;
  logic [2:0] pend = '0, cur = '0;
  logic [2:0] mfb [76800] = '{default: 3'd0};
  vec_t tab [9];
  vga_fb_scanout #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
    .VGA_CLK(vga_clk), .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .frame_start(frame_start)
  );
  assign got = {vga_clk, hs, vs, blank_n, sync_n, frame_start, r, g, b};
  always #10 clk = ~clk;
  function automatic int pix_addr(input int p);
    int hh = p % HT, vv = (p / HT) % VT;
    return (hh < HV && vv < VV) ? (vv / 2) * 320 + hh / 2 : 0;
  endfunction
  // t counts clk edges since the last reset edge; pixel n's outputs appear after edge 2n+4
  function automatic logic [35:0] expect_now(input int tt, input logic [2:0] col);
    int p, hh, vv;
    logic vis, hsn, vsn, fs;
    vis = 1'b0; hsn = 1'b1; vsn = 1'b1;
    if (tt >= 4) begin
      p = tt / 2 - 2;
      hh = p % HT;
      vv = (p / HT) % VT;
      vis = hh < HV && vv < VV;
      hsn = !(hh >= HV + HF && hh < HV + HF + HSY);
      vsn = !(vv >= VV + VF && vv < VV + VF + VSY);
    end
    fs = (tt % 2 == 1) && ((tt / 2) % FR == 0);
    return {tt % 2 == 1, hsn, vsn, vis, 1'b1, fs,
            vis ? {{10{col[2]}}, {10{col[1]}}, {10{col[0]}}} : 30'd0};
  endfunction
  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask
  task automatic check(input string nm, input logic [35:0] act, input logic [35:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s t=%0d got %h want %h", nm, t, act, want);
    end
  endtask
  task automatic wait_t(input int target);
    int n = 0;
    do begin @(negedge clk); n++; end while (t != target && n < 40000);
    if (t != target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_t timeout t=%0d want %0d", t, target);
    end
  endtask
  task automatic write_px(input logic [8:0] wx, input logic [7:0] wy, input logic [2:0] wc);
    @(negedge clk);
    plot = 1'b1; x = wx; y = wy; colour = wc;
    @(negedge clk);
    plot = 1'b0;
  endtask
  initial forever begin
    @(posedge clk);
    t = reset ? 0 : t + 1;
    if (t >= 3 && t % 2 == 1) pend = mfb[pix_addr(t / 2 - 1)];
    if (t >= 4 && t % 2 == 0) cur = pend;
    if (!reset && plot && x < 320 && y < 240) mfb[int'(y) * 320 + int'(x)] = colour;
  end
  initial forever begin
    @(negedge clk);
    check("scan", got, expect_now(t, cur));
    if (miscompares >= 40) report();
  end
  initial begin
    tab[0] = '{1'b1, 9'd0,   8'd0,   3'd5, 0,  0,  MAG};
    tab[1] = '{1'b1, 9'd31,  8'd0,   3'd2, 2,  0,  BLK};
    tab[2] = '{1'b1, 9'd320, 8'd5,   3'd7, 62, 0,  GRN};
    tab[3] = '{1'b1, 9'd330, 8'd2,   3'd7, 64, 0,  BLK};
    tab[4] = '{1'b1, 9'd31,  8'd23,  3'd7, 1,  1,  MAG};
    tab[5] = '{1'b1, 9'd5,   8'd240, 3'd7, 20, 6,  BLK};
    tab[6] = '{1'b0, 9'd0,   8'd0,   3'd0, 0,  12, BLK};
    tab[7] = '{1'b0, 9'd0,   8'd0,   3'd0, 62, 46, WHT};
    tab[8] = '{1'b0, 9'd0,   8'd0,   3'd0, 63, 47, WHT};
    repeat (5) @(negedge clk);
    check("reset_hold", got, RST);
    reset = 1'b0;
    wait_t(1);
    check("first_frame_start", {35'd0, frame_start}, 36'd1);
    for (int i = 0; i < 9; i++) if (tab[i].we) write_px(tab[i].wx, tab[i].wy, tab[i].wc);
    base = (t / 2 / FR + 1) * FR;
    for (int i = 0; i < 9; i++) begin
      wait_t(2 * (base + tab[i].pv * HT + tab[i].ph) + 4);
      check($sformatf("pix_%0d_%0d", tab[i].ph, tab[i].pv), {6'd0, r, g, b}, {6'd0, tab[i].rgb});
    end
    base = (t / 2 / FR + 1) * FR;
    c = base + 20 * HT + 40;
    wait_t(2 * c + 2);
    plot = 1'b1; x = 9'd20; y = 8'd10; colour = 3'd2;
    @(negedge clk);
    plot = 1'b0;
    wait_t(2 * c + 4);
    check("rdw_old", {6'd0, r, g, b}, {6'd0, BLK});
    wait_t(2 * c + 6);
    check("rdw_next_read", {6'd0, r, g, b}, {6'd0, GRN});
    wait_t(2 * (c + FR) + 4);
    check("rdw_next_frame", {6'd0, r, g, b}, {6'd0, GRN});
    wait_t(2 * (c + FR + HT + 1) + 4);
    check("rdw_next_frame_41_21", {6'd0, r, g, b}, {6'd0, GRN});
    base = (t / 2 / FR + 1) * FR;
    wait_t(2 * (base + 20 * HT + 30));
    reset = 1'b1; plot = 1'b1; x = 9'd3; y = 8'd0; colour = 3'd7;
    @(negedge clk);
    check("mid_reset", got, RST);
    reset = 1'b0; plot = 1'b0;
    wait_t(1);
    check("restart_frame_start", {35'd0, frame_start}, 36'd1);
    wait_t(4);
    check("restart_pix_0_0", {6'd0, r, g, b}, {6'd0, MAG});
    wait_t(16);
    check("write_in_reset_dropped", {6'd0, r, g, b}, {6'd0, BLK});
    wait_t(2 * 62 + 4);
    check("restart_pix_62_0", {6'd0, r, g, b}, {6'd0, GRN});
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      plot = $urandom_range(0, 2) == 0;
      x = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 31));
      y = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 23));
      colour = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    plot = 1'b0;
    repeat (FR * 2 + 100) @(negedge clk);
    report();
  end
endmodule
